viterbi_decoder: RTL and testbench
==================================

VITERBI_DECODER -- requirements
Module: viterbi_decoder

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- TB_DEPTH, 16, survivor/traceback length in symbols.
- PM_W, 8, path-metric width in bits.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on its rising edge.
- rst, input, 1, asynchronous active-low reset.
- enable, input, 1, d_in holds a valid coded symbol this cycle.
- d_in, input, 2, hard-decision coded symbol {c1,c0}.
- d_out, output, 1, registered decoded data bit.
REQ-003 One clock; reset is asynchronous and active-low.

Function
REQ-004 The code is rate 1/2, constraint length 3: c1 = b ^ b[n-1] ^ b[n-2] (g=111); c0 = b ^ b[n-2] (g=101); the encoder starts in state 00.
REQ-005 Trellis state = {b[n-1], b[n-2]}, 4 states; input bit b moves state s to {b, s[1]}.
REQ-006 On each enable cycle the block updates all four states in one cycle with add-compare-select.
- Branch metric = Hamming distance, 0..2, between d_in and the branch's expected {c1,c0}.
- New metric of each state = min over its two predecessors of (old metric + branch metric).
REQ-007 ACS tie: select the predecessor with the lower state index.
REQ-008 Survivors use register exchange, one TB_DEPTH-bit register per state.
- The new survivor is the selected predecessor's survivor shifted left one place.
- The destination state's input bit enters at the LSB.
REQ-009 Normalization: after ACS, if every metric has its MSB set, clear the MSB of all four metrics.
- Metrics never overflow or wrap.
- No saturation logic beyond this normalization.
REQ-010 Best state = the state with the minimum new metric; ties go to the lowest index.
REQ-011 On the same edge as the ACS update, d_out <= MSB of the best state's new survivor.
- This is the decoded bit for the symbol consumed TB_DEPTH-1 enable cycles earlier.
- d_out is visible the cycle after that enable.
REQ-012 enable low: metrics, survivors and d_out all hold; d_in is ignored.
- There is no flush or end-of-frame input; the bench supplies TB_DEPTH extra symbols to drain the decoder.
REQ-013 Symbols arrive at most one per cycle; back-to-back enables are required to work at full rate.
REQ-014 With gaps in enable, decoded output is identical to back-to-back operation; only its timing stretches.
REQ-015 Error performance for one flipped coded bit in every 8 symbols:
- Decoded output equals the original data exactly, after the initial latency.
- This relies on free distance 5.

Reset
REQ-016 While rst is low, regardless of clk:
- metric[0] = 0; metric[1..3] = 2^(PM_W-2), a start bias.
- All survivors = 0; d_out = 0.
REQ-017 rst asserted mid-stream aborts decoding immediately.
- The first enabled symbol after release is treated as the first symbol from encoder state 00.
REQ-018 Reset release needs no synchronizer inside the block; the bench deasserts rst away from the clk edge.

Verification
REQ-019 After reset, 40 enabled symbols of 00 -> d_out stays 0 throughout; metric[0] stays 0.
REQ-020 Data 1,0,1,1,0,0,1,0 then 16 zero bits, encoded with REQ-004, enable high:
- The coded stream starts 11,10,00,01.
- d_out reproduces 1,0,1,1,0,0,1,0 starting 16 cycles after the first symbol (TB_DEPTH-1 enables plus the register stage).
REQ-021 Pseudo-random 256-bit stream, encoded, c1 inverted on every 8th symbol (symbols 7,15,23,...) -> zero decoded bit errors over all 256 bits after latency alignment.
REQ-022 Same clean stream with enable deasserted at random 30% of cycles -> d_out bit sequence is identical to REQ-020/021; d_out holds during gaps.
REQ-023 Two adjacent coded bits flipped in a single symbol, preceded and followed by 20 clean symbols -> output remains error-free.
REQ-024 rst pulsed low for 1 cycle in the middle of a stream:
- d_out goes to 0 asynchronously.
- After release, a fresh encoded stream decodes correctly with the REQ-020 latency.

Source files
------------

// File: rtl/viterbi_decoder.sv
// ---------------------------------------------------------------------------
// viterbi_decoder
//   Hard-decision Viterbi decoder for the rate 1/2, K=3 convolutional code
//   (g1 = 111 -> c1, g0 = 101 -> c0). The decoder keeps four path metrics
//   and uses register-exchange survivors. One symbol is consumed per enabled
//   cycle. The decoded bit leaves the oldest end of the best state's survivor.
//
// Ports
//   clk     in   1  single clock, rising-edge state updates
//   rst     in   1  asynchronous active-low reset
//   enable  in   1  d_in carries a valid coded symbol this cycle
//   d_in    in   2  hard-decision coded symbol {c1,c0}
//   d_out   out  1  registered decoded bit (TB_DEPTH-1 enables of delay)
// ---------------------------------------------------------------------------
module viterbi_decoder #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] d_in,
    output logic       d_out
);

    // Non-zero states start behind state 00 so the trellis is anchored to
    // the encoder's known start state.
    localparam logic [PM_W-1:0] START_BIAS = {2'b01, {(PM_W-2){1'b0}}};
    localparam logic [PM_W-1:0] MSB_MASK   = {1'b1, {(PM_W-1){1'b0}}};

    logic [PM_W-1:0]     metric_q     [4];
    logic [PM_W-1:0]     metric_d     [4];
    logic [TB_DEPTH-1:0] surv_q       [4];
    logic [TB_DEPTH-1:0] surv_d       [4];
    logic                d_out_q;
    logic                d_out_d;

    logic [PM_W-1:0]     cand0_s      [4];
    logic [PM_W-1:0]     cand1_s      [4];
    logic [PM_W-1:0]     acs_metric_s [4];
    logic [1:0]          sel_pred_s   [4];
    logic                all_msb_s;
    logic [1:0]          best_s;

    // Predecessor y (0 or 1) of destination state ns = {b, x} is {x, y}.
    function automatic logic [1:0] pred_state(input logic [1:0] ns, input logic y);
        return {ns[0], y};
    endfunction

    // Encoder output on the branch pred -> dest; the input bit is dest[1].
    function automatic logic [1:0] branch_sym(input logic [1:0] pred, input logic [1:0] dest);
        logic b;
        b = dest[1];
        return {b ^ pred[1] ^ pred[0], b ^ pred[0]};
    endfunction

    // Hamming distance between the received symbol and a branch symbol.
    function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] expect_sym);
        logic [1:0] diff;
        diff = rx ^ expect_sym;
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

    // Add-compare-select for all four destination states, plus survivor exchange.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cand0_s[i] = metric_q[pred_state(2'(i), 1'b0)]
                       + {{(PM_W-2){1'b0}},
                          branch_metric(d_in, branch_sym(pred_state(2'(i), 1'b0), 2'(i)))};
            cand1_s[i] = metric_q[pred_state(2'(i), 1'b1)]
                       + {{(PM_W-2){1'b0}},
                          branch_metric(d_in, branch_sym(pred_state(2'(i), 1'b1), 2'(i)))};
            // Strict less-than: a tie keeps the lower-indexed predecessor.
            if (cand1_s[i] < cand0_s[i]) begin
                sel_pred_s[i]   = pred_state(2'(i), 1'b1);
                acs_metric_s[i] = cand1_s[i];
            end else begin
                sel_pred_s[i]   = pred_state(2'(i), 1'b0);
                acs_metric_s[i] = cand0_s[i];
            end
            // Destination state's input bit (its MSB) enters at the LSB.
            surv_d[i] = {surv_q[sel_pred_s[i]][TB_DEPTH-2:0], (i >= 2) ? 1'b1 : 1'b0};
        end
    end

    // Normalization: once every metric is in the upper half, drop the MSB
    // from all of them; relative distances are preserved.
    always_comb begin
        all_msb_s = acs_metric_s[0][PM_W-1] & acs_metric_s[1][PM_W-1]
                  & acs_metric_s[2][PM_W-1] & acs_metric_s[3][PM_W-1];
        for (int i = 0; i < 4; i++) begin
            if (all_msb_s) begin
                metric_d[i] = acs_metric_s[i] & ~MSB_MASK;
            end else begin
                metric_d[i] = acs_metric_s[i];
            end
        end
    end

    // Best-state search (lowest index wins ties) and decoded bit selection.
    always_comb begin
        best_s = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (metric_d[i] < metric_d[best_s]) begin
                best_s = 2'(i);
            end else begin
                best_s = best_s;
            end
        end
        d_out_d = surv_d[best_s][TB_DEPTH-1];
    end

    // State registers: metrics, survivors and the output bit advance only on enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                metric_q[i] <= (i == 0) ? {PM_W{1'b0}} : START_BIAS;
                surv_q[i]   <= {TB_DEPTH{1'b0}};
            end
            d_out_q <= 1'b0;
        end else if (enable) begin
            for (int i = 0; i < 4; i++) begin
                metric_q[i] <= metric_d[i];
                surv_q[i]   <= surv_d[i];
            end
            d_out_q <= d_out_d;
        end
    end

    assign d_out = d_out_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// ---------------------------------------------------------------------------
// tb_viterbi_decoder
//   Directed and pseudo-random self-checking bench for viterbi_decoder.
//   A hand-encoded vector table covers the reference stream; streams encoded
//   by a bench-side encoder cover error correction, enable gaps and reset.
// ---------------------------------------------------------------------------
module tb_viterbi_decoder;

    localparam int TB_DEPTH = 16;
    localparam int PM_W     = 8;
    localparam int NVEC     = 24;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] d_in;
    logic       d_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] sym;
        logic       exp_dout;
    } vec_t;

    vec_t vecs [NVEC];
    logic data_bits [300];

    viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .d_in   (d_in),
        .d_out  (d_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    function automatic logic [1:0] encode(input logic b, input logic [1:0] s);
        return {b ^ s[1] ^ s[0], b ^ s[0]};
    endfunction

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic en, input logic [1:0] sym);
        @(negedge clk);
        enable = en;
        d_in   = sym;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_m0"}, 0, 32'(dut.metric_q[0]), 32'd0);
        for (int i = 1; i < 4; i++) begin
            check({name, "_mi"}, i, 32'(dut.metric_q[i]), 32'd64);
        end
        for (int i = 0; i < 4; i++) begin
            check({name, "_surv"}, i, 32'(dut.surv_q[i]), 32'd0);
        end
        check({name, "_dout"}, 0, 32'(d_out), 32'd0);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        rst    = 1'b0;
        enable = 1'b0;
        #1;
        check({name, "_async"}, 0, 32'(d_out), 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state(name);
    endtask

    task automatic apply_table(input string name);
        for (int i = 0; i < NVEC; i++) begin
            step(1'b1, vecs[i].sym);
            check(name, i, 32'(d_out), 32'(vecs[i].exp_dout));
        end
    endtask

    // mode 0: clean, 1: c1 inverted on symbols 7,15,..., 2: both bits of flip_sym inverted.
    task automatic run_stream(input string name, input int nbits, input int mode,
                              input int flip_sym, input int gap_pct);
        logic [1:0] st;
        logic       exp_last;
        logic       b;
        logic [1:0] sym;
        int         g;
        st       = 2'b00;
        exp_last = 1'b0;
        for (int k = 0; k < nbits + TB_DEPTH; k++) begin
            b   = (k < nbits) ? data_bits[k] : 1'b0;
            sym = encode(b, st);
            st  = {b, st[1]};
            if (mode == 1 && (k % 8) == 7) sym[1] = ~sym[1];
            if (mode == 2 && k == flip_sym) sym = sym ^ 2'b11;
            g = 0;
            while (gap_pct > 0 && g < 8 && $urandom_range(99, 0) < gap_pct) begin
                step(1'b0, 2'($urandom_range(3, 0)));
                check({name, "_hold"}, k, 32'(d_out), 32'(exp_last));
                g++;
            end
            step(1'b1, sym);
            if (k >= TB_DEPTH - 1) begin
                exp_last = (k - (TB_DEPTH - 1) < nbits) ? data_bits[k - (TB_DEPTH - 1)] : 1'b0;
            end else begin
                exp_last = 1'b0;
            end
            check(name, k, 32'(d_out), 32'(exp_last));
        end
    endtask

    initial begin
        logic [1:0] st;

        // Hand-encoded reference: data 1,0,1,1,0,0,1,0 followed by zeros.
        for (int i = 0; i < NVEC; i++) vecs[i] = '{2'b00, 1'b0};
        vecs[0].sym = 2'b11; vecs[1].sym = 2'b10; vecs[2].sym = 2'b00;
        vecs[3].sym = 2'b01; vecs[4].sym = 2'b01; vecs[5].sym = 2'b11;
        vecs[6].sym = 2'b11; vecs[7].sym = 2'b10; vecs[8].sym = 2'b11;
        vecs[15].exp_dout = 1'b1; vecs[16].exp_dout = 1'b0;
        vecs[17].exp_dout = 1'b1; vecs[18].exp_dout = 1'b1;
        vecs[19].exp_dout = 1'b0; vecs[20].exp_dout = 1'b0;
        vecs[21].exp_dout = 1'b1; vecs[22].exp_dout = 1'b0;

        rst    = 1'b1;
        enable = 1'b0;
        d_in   = 2'b00;
        #2;
        rst = 1'b0;
        #1;
        check("por_dout", 0, 32'(d_out), 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("por");

        // All-zero symbols: output and metric[0] stay at zero.
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 2'b00);
            check("zeros_dout", k, 32'(d_out), 32'd0);
            check("zeros_m0", k, 32'(dut.metric_q[0]), 32'd0);
        end

        do_reset("rst_a");
        apply_table("ref_table");

        for (int i = 0; i < 256; i++) data_bits[i] = 1'($urandom_range(1, 0));
        do_reset("rst_b");
        run_stream("err_every8", 256, 1, 0, 0);

        do_reset("rst_c");
        run_stream("gaps", 256, 0, 0, 30);

        for (int i = 0; i < 41; i++) data_bits[i] = 1'($urandom_range(1, 0));
        do_reset("rst_d");
        run_stream("double_flip", 41, 2, 20, 0);

        // Mid-stream reset: stream of ones, then a one-cycle reset pulse.
        do_reset("rst_e");
        st = 2'b00;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, encode(1'b1, st));
            st = {1'b1, st[1]};
        end
        check("mid_pre", 0, 32'(d_out), 32'd1);
        @(negedge clk);
        #2;
        rst    = 1'b0;
        enable = 1'b0;
        #1;
        check("mid_async", 0, 32'(d_out), 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("mid_rel");
        apply_table("mid_table");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
